// File: rtl/auto_drive_pkg.sv
// Shared state codes and direction constants for auto_drive_ctrl and the turning unit.
// TURN (4'b0111) is the code the turning unit keys on.
package auto_drive_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0000,
        ST_FORWARD    = 4'b0001,
        ST_STOP_CHECK = 4'b0010,
        ST_EXIT       = 4'b0011,
        ST_REARM      = 4'b0100,
        ST_TURN       = 4'b0111,
        ST_FAULT      = 4'b1111
    } state_e;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    localparam int                 TIMER_W   = 12;
    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

    // Terminal value for a dwell of 'cycles' clocks, counted from 0.
    function automatic logic [TIMER_W-1:0] match_val(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/auto_drive_timer.sv
// 12-bit saturating up-counter with synchronous clear and a terminal-match flag.
// Shared by the settle, exit and turn-watchdog intervals.
module auto_drive_timer
    import auto_drive_pkg::*;
(
    input  logic               clk_ms,
    input  logic               rst,
    input  logic               i_clr,
    input  logic [TIMER_W-1:0] i_match,
    output logic               o_match
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk_ms) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (r_count != TIMER_MAX) begin
            r_count <= r_count + TIMER_W'(1);
        end
    end

    assign o_match = (r_count == i_match);

endmodule

// File: rtl/auto_drive_ctrl.sv
// Autonomous drive sequencer: forward, stop-and-look, turn, clear-out.
// Define AUTO_DRIVE_TURN_TIMEOUT_EN to enable the turn watchdog and FAULT state.
//
// state      | meaning
// IDLE       | autonomous mode off
// FORWARD    | driving forward, watching front detector
// STOP_CHECK | stopped, settling before sampling detectors
// TURN       | turning unit active, waiting for finish_turning
// REARM      | one-cycle gap between the two halves of a U-turn
// EXIT       | driving forward to clear the corner
// FAULT      | turn watchdog expired (watchdog builds only)
module auto_drive_ctrl
    import auto_drive_pkg::*;
#(
    parameter int SETTLE_MS  = 200,
    parameter int EXIT_MS    = 300,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic       clk_ms,
    input  logic       rst,
    input  logic       auto_en,
    input  logic       front_blocked,
    input  logic       left_blocked,
    input  logic       right_blocked,
    input  logic       finish_turning,
    output logic [3:0] state,
    output logic       left_right,
    output logic       move_forward,
    output logic [7:0] turn_count,
    output logic       fault
);

    state_e             r_state;
    state_e             w_next_state;
    logic               r_left_right;
    logic               w_next_lr;
    logic               r_uturn;
    logic               w_next_uturn;
    logic [7:0]         r_turn_count;
    logic               w_count_inc;
    logic               w_tmr_clr;
    logic               w_tmr_match;
    logic [TIMER_W-1:0] w_tmr_limit;

    always_comb begin
        case (r_state)
            ST_STOP_CHECK: w_tmr_limit = match_val(SETTLE_MS);
            ST_EXIT:       w_tmr_limit = match_val(EXIT_MS);
            default:       w_tmr_limit = match_val(TIMEOUT_MS);
        endcase
    end

    // Any state change restarts the interval, so each dwell counts from 0.
    assign w_tmr_clr = (w_next_state != r_state) || !auto_en;

    auto_drive_timer u_timer (
        .clk_ms  (clk_ms),
        .rst     (rst),
        .i_clr   (w_tmr_clr),
        .i_match (w_tmr_limit),
        .o_match (w_tmr_match)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_lr    = r_left_right;
        w_next_uturn = r_uturn;
        w_count_inc  = 1'b0;
        if (!auto_en) begin
            w_next_state = ST_IDLE;
            w_next_lr    = LEFT;
            w_next_uturn = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_FORWARD;
                ST_FORWARD: begin
                    if (front_blocked) w_next_state = ST_STOP_CHECK;
                end
                ST_STOP_CHECK: begin
                    if (w_tmr_match) begin
                        if (!front_blocked) begin
                            w_next_state = ST_FORWARD;
                        end else if (!left_blocked) begin
                            w_next_state = ST_TURN;
                            w_next_lr    = LEFT;
                        end else if (!right_blocked) begin
                            w_next_state = ST_TURN;
                            w_next_lr    = RIGHT;
                        end else begin
                            w_next_state = ST_TURN;
                            w_next_lr    = LEFT;
                            w_next_uturn = 1'b1;
                        end
                    end
                end
                ST_TURN: begin
                    if (finish_turning) begin
                        w_count_inc = 1'b1;
                        if (r_uturn) begin
                            w_next_uturn = 1'b0;
                            w_next_state = ST_REARM;
                        end else begin
                            w_next_state = ST_EXIT;
                        end
                    end
`ifdef AUTO_DRIVE_TURN_TIMEOUT_EN
                    else if (w_tmr_match) begin
                        w_next_state = ST_FAULT;
                    end
`endif
                end
                // Leaving 4'b0111 for one cycle lets the turning unit re-arm.
                ST_REARM: begin
                    w_next_state = ST_TURN;
                    w_next_lr    = LEFT;
                end
                ST_EXIT: begin
                    if (front_blocked) begin
                        w_next_state = ST_STOP_CHECK;
                    end else if (w_tmr_match) begin
                        w_next_state = ST_FORWARD;
                    end
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_ms) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_left_right <= LEFT;
            r_uturn      <= 1'b0;
            r_turn_count <= '0;
        end else begin
            r_state      <= w_next_state;
            r_left_right <= w_next_lr;
            r_uturn      <= w_next_uturn;
            if (w_count_inc) r_turn_count <= r_turn_count + 8'd1;
        end
    end

    assign state        = r_state;
    assign left_right   = r_left_right;
    assign move_forward = (r_state == ST_FORWARD) || (r_state == ST_EXIT);
    assign turn_count   = r_turn_count;
`ifdef AUTO_DRIVE_TURN_TIMEOUT_EN
    assign fault        = (r_state == ST_FAULT);
`else
    assign fault        = 1'b0;
`endif

endmodule

// File: doc/auto_drive_ctrl.md
AUTO_DRIVE_CTRL -- requirements
Module: auto_drive_ctrl

Interface
REQ-001 Parameter SETTLE_MS, default 200: stop-and-look dwell in clk_ms cycles, legal range 1..4095.
REQ-002 Parameter EXIT_MS, default 300: forward clear-out time after a turn in clk_ms cycles, legal range 1..4095.
REQ-003 Parameter TIMEOUT_MS, default 2000: turn watchdog limit in clk_ms cycles, legal range 1..4095.
REQ-004 Port clk_ms, input, 1: the only clock, 1 kHz tick; all logic is on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port auto_en, input, 1: autonomous mode enable, level-sensitive.
REQ-007 Port front_blocked, left_blocked, right_blocked, inputs, 1 each: obstacle detectors, 1 = blocked.
REQ-008 Port finish_turning, input, 1: turning-unit done flag; it stays high until state leaves 4'b0111.
REQ-009 Port state, output, 4: controller state code, driven to the turning unit.
REQ-010 Port left_right, output, 1: turn direction, 0 = left, 1 = right.
REQ-011 Port move_forward, output, 1: drive-forward command.
REQ-012 Port turn_count, output, 8: number of completed turns, wraps 255->0.
REQ-013 Port fault, output, 1: turn watchdog fault flag.

Function
REQ-014 State codes: IDLE 4'b0000, FORWARD 4'b0001, STOP_CHECK 4'b0010, EXIT 4'b0011, REARM 4'b0100, TURN 4'b0111, FAULT 4'b1111.
- state is the registered FSM state, output directly.
REQ-015 auto_en=0 forces IDLE on the next edge from any state; timer, U-turn flag and left_right clear; turn_count holds.
REQ-016 IDLE -> FORWARD when auto_en=1.
REQ-017 FORWARD: move_forward=1; front_blocked=1 -> STOP_CHECK and timer clears to 0.
REQ-018 STOP_CHECK: move_forward=0.
- Timer increments each cycle.
- When timer reaches SETTLE_MS-1, detectors are sampled on that edge with priority front clear, then left clear, then right clear.
- Front clear -> FORWARD.
- Left clear -> TURN with left_right=0.
- Right clear -> TURN with left_right=1.
- All blocked -> TURN with left_right=0 and uturn=1.
REQ-019 TURN: move_forward=0; left_right held stable; timer counts.
- finish_turning=1 with uturn=0: turn_count+1 -> EXIT.
- finish_turning=1 with uturn=1: turn_count+1, uturn clears -> REARM.
REQ-020 REARM lasts exactly one cycle (move_forward=0), then -> TURN with left_right=0 and timer cleared.
- This exists so the turning unit sees state leave 4'b0111 and re-arms its counter.
REQ-021 EXIT: move_forward=1; timer counts.
- front_blocked=1 -> STOP_CHECK (priority over expiry).
- Timer reaches EXIT_MS-1 -> FORWARD.
REQ-022 The timer is 12-bit, saturates at 4095, and clears on every state change.
REQ-023 finish_turning is ignored in every state except TURN.
REQ-024 turn_count increments at most once per TURN visit; a U-turn adds 2.

Reset
REQ-025 rst=1 on an edge sets state=IDLE, timer=0, uturn=0, left_right=0, move_forward=0, turn_count=0, fault=0.
- rst takes priority over auto_en.
- Reset mid-TURN abandons the turn with no count increment.

Configuration
REQ-026 Macro AUTO_DRIVE_TURN_TIMEOUT_EN defined: in TURN, timer reaching TIMEOUT_MS-1 without finish_turning -> FAULT.
- FAULT: fault=1, move_forward=0.
- FAULT is left only via auto_en=0 (-> IDLE, fault clears) or rst.
- finish_turning on the same edge as timeout wins.
REQ-027 Macro undefined: no FAULT state; TURN waits indefinitely; fault tied 0.

Structure
REQ-028 A shared package holds the 4-bit state code constants (4'b0111 = TURN is common with the turning unit) and the direction constants LEFT=0/RIGHT=1.
REQ-029 One sub-module, auto_drive_timer: 12-bit saturating counter with clear and a terminal-match compare.
- Used for settle, exit and watchdog timing.

Verification
REQ-030 rst, auto_en=1, front_blocked pulse, then left_blocked=0 -> state 0001, then 0010 for 200 cycles, then 0111 with left_right=0; finish_turning -> 0011 for 300 cycles, then 0001; turn_count=1.
REQ-031 Front and left blocked, right clear at settle end -> TURN with left_right=1.
REQ-032 All three blocked -> 0111, finish -> exactly one cycle of 0100, then 0111 again with left_right=0; second finish -> turn_count=2, then EXIT.
REQ-033 front_blocked raised at EXIT cycle 100 -> STOP_CHECK on the next edge.
REQ-034 With macro defined, finish_turning never asserted -> state 1111 and fault=1 after 2000 TURN cycles; auto_en=0 -> 0000, fault=0.
REQ-035 rst asserted mid-TURN and mid-STOP_CHECK -> all outputs at reset values on the next edge; turn_count=0.
